// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
//   Instruction-memory request/response bundle between the fetch sequencer
//   and IM.
//   imem_req    : fetch request valid (fetch -> IM)
//   imem_addr   : fetch address, held while imem_req && !imem_ready
//   imem_ready  : IM accepts the request this cycle (IM -> fetch)
//   imem_rvalid : IM returns data this cycle, at least one cycle after accept
//   imem_rdata  : returned instruction word
//   master = fetch side, slave = memory side.
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer for the P4 MIPS core. Owns the PC, issues one
//   fetch at a time to IM, holds the fetched word for decode and applies
//   branch/jump redirects coming back from execute.
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous, active-low reset (0 = reset)
//   stall        : decode not ready, held instruction is not consumed
//   redir_valid  : branch/jump taken this cycle
//   redir_target : redirect target address
//   imem         : fetch_ctrl_if.master (req/addr/ready/rvalid/rdata)
//   instr_valid  : instr/instr_pc hold a deliverable instruction
//   instr        : fetched instruction word
//   instr_pc     : address of instr
//   pc           : address of the next/current fetch
//   fault        : sticky, a misaligned redirect target was seen
//
// Build option
//   DELAY_SLOT_EN : when defined, MIPS branch-delay-slot semantics. A
//                   redirect never squashes; the target is kept pending and
//                   replaces pc+4 at the next consume. When undefined, a
//                   redirect squashes whatever is in flight and restarts.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [31:0]       redir_target,
  fetch_ctrl_if.master      imem,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic [31:0]       pc,
  output logic              fault
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        fault_q, fault_d;

  logic redir_ok;
  logic redir_bad;
  logic consume;

  assign redir_ok  = redir_valid && (redir_target[1:0] == 2'b00);
  assign redir_bad = redir_valid && (redir_target[1:0] != 2'b00);
  // A redirect in the same cycle as !stall voids the consume.
  assign consume   = (state_q == S_OUT) && !stall && !redir_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (imem.imem_ready) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (imem.imem_rvalid) begin
`ifdef DELAY_SLOT_EN
          instr_d = imem.imem_rdata;
          ipc_d   = pc_q;
          state_d = S_OUT;
`else
          // A pending (or simultaneous) redirect means this word belongs to
          // a squashed fetch: drop it and restart at the target.
          if (pend_q || redir_ok) begin
            pc_d    = redir_ok ? redir_target : tgt_q;
            pend_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = imem.imem_rdata;
            ipc_d   = pc_q;
            state_d = S_OUT;
          end
`endif
        end
      end

      S_OUT: begin
`ifdef DELAY_SLOT_EN
        if (consume) begin
          pc_d    = pend_q ? tgt_q : pc_q + 32'd4;
          pend_d  = 1'b0;
          state_d = S_REQ;
        end
`else
        if (redir_ok) begin
          pc_d    = redir_target;
          state_d = S_REQ;
        end else if (consume) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
`endif
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase

    // Remember redirects that cannot take effect this cycle; a later one
    // overwrites the target.
`ifdef DELAY_SLOT_EN
    if (redir_ok && (state_q != S_HALT)) begin
      pend_d = 1'b1;
      tgt_d  = redir_target;
    end
`else
    if (redir_ok && ((state_q == S_IDLE) || (state_q == S_REQ) ||
                     ((state_q == S_WAIT) && !imem.imem_rvalid))) begin
      pend_d = 1'b1;
      tgt_d  = redir_target;
    end
`endif

    // A misaligned target is fatal until reset, from any live state.
    if (redir_bad && (state_q != S_HALT)) begin
      fault_d = 1'b1;
      state_d = S_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
    end
  end

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == S_OUT);
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;
  assign pc             = pc_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic        fault;

  fetch_ctrl_if imem();

  fetch_ctrl u_dut (
    .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid),
    .redir_target(redir_target), .imem(imem), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .pc(pc), .fault(fault)
  );

  // Second instance exercising PC wrap-around from the top of memory.
  logic        rst_w;
  logic        w_valid;
  logic [31:0] w_instr, w_ipc, w_pc;
  logic        w_fault;
  fetch_ctrl_if imw();

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(rst_w), .stall(1'b0), .redir_valid(1'b0),
    .redir_target(32'h0), .imem(imw), .instr_valid(w_valid),
    .instr(w_instr), .instr_pc(w_ipc), .pc(w_pc), .fault(w_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Zero-wait memory for the wrap instance.
  assign imw.imem_ready = 1'b1;
  always @(posedge clk) begin
    imw.imem_rvalid <= imw.imem_req;
    imw.imem_rdata  <= mem_word(imw.imem_addr);
  end

  logic [31:0] wq_ipc[$];
  logic [31:0] wq_ins[$];
  logic [31:0] wq_pc[$];
  always @(negedge clk) begin
    if (rst_w && w_valid && !w_fault && wq_ipc.size() < 4) begin
      wq_ipc.push_back(w_ipc);
      wq_ins.push_back(w_instr);
      wq_pc.push_back(w_pc);
    end
  end

  // Behavioural IM for the main instance: random acceptance, one request in
  // flight, configurable return latency.
  int ready_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  initial begin
    bit          busy;
    bit          drv_ready;
    bit          last_req;
    bit          rv;
    int          cnt;
    logic [31:0] baddr;
    logic [31:0] last_addr;
    busy = 0; drv_ready = 0; last_req = 0; cnt = 0; baddr = '0; last_addr = '0;
    imem.imem_ready  = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (drv_ready && last_req) begin
        busy  = 1;
        cnt   = int'($urandom_range(lat_max, lat_min));
        baddr = last_addr;
      end
      rv = 0;
      if (busy) begin
        cnt = cnt - 1;
        if (cnt <= 0) begin
          rv   = 1;
          busy = 0;
        end
      end
      imem.imem_rvalid = rv;
      imem.imem_rdata  = rv ? mem_word(baddr) : 32'hDEAD_BEEF;
      last_req  = imem.imem_req;
      last_addr = imem.imem_addr;
      drv_ready = !busy && (int'($urandom_range(99, 0)) < ready_pct);
      imem.imem_ready = drv_ready;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; redir_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          found, got;
    logic [31:0] first_pc, first_ins;
    logic [31:0] exp_next, ptgt, prev_addr;
    bit          ppend, prev_req, prev_ready, s, r;
    int          consumes;

    reset = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_target = '0; rst_w = 1'b0;

    // stall, req, pc, instr_valid, instr_pc  (sampled before this row's inputs act)
    tbl[0]  = '{1'b0, 1'b0, 32'h3000, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h3000, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h3000, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h3000, 1'b1, 32'h3000};
    tbl[4]  = '{1'b0, 1'b1, 32'h3004, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h3004, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h3004, 1'b1, 32'h3004};
    tbl[7]  = '{1'b1, 1'b0, 32'h3004, 1'b1, 32'h3004};
    tbl[8]  = '{1'b1, 1'b0, 32'h3004, 1'b1, 32'h3004};
    tbl[9]  = '{1'b1, 1'b0, 32'h3004, 1'b1, 32'h3004};
    tbl[10] = '{1'b1, 1'b0, 32'h3004, 1'b1, 32'h3004};
    tbl[11] = '{1'b0, 1'b0, 32'h3004, 1'b1, 32'h3004};
    tbl[12] = '{1'b0, 1'b1, 32'h3008, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 32'h3008, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 32'h3008, 1'b1, 32'h3008};

    // ---------------- basic sequence from reset, with a 5-cycle stall
    apply_reset();
    rst_w = 1'b1;
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    for (int i = 0; i < 15; i++) begin
      chk1($sformatf("tbl%0d_req", i), imem.imem_req, tbl[i].req);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem.imem_addr, tbl[i].pc);
      chk1($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_ipc", i), instr_pc, tbl[i].ipc);
        chk($sformatf("tbl%0d_instr", i), instr, mem_word(tbl[i].ipc));
      end
      chk1($sformatf("tbl%0d_fault", i), fault, 1'b0);
      stall = tbl[i].stall;
      @(negedge clk);
    end
    stall = 1'b0;

    // ---------------- wrap instance: FFFF_FFFC then 0
    chk("wrap_count_ok", (wq_ipc.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
    if (wq_ipc.size() >= 2) begin
      chk("wrap_first_pc", wq_ipc[0], 32'hFFFF_FFFC);
      chk("wrap_second_pc", wq_ipc[1], 32'h0);
      chk("wrap_second_instr", wq_ins[1], mem_word(32'h0));
      chk("wrap_pc_held", wq_pc[1], 32'h0);
    end

    // ---------------- redirect sequence
    ready_pct = 100; lat_min = 2; lat_max = 2;
    apply_reset();
`ifdef DELAY_SLOT_EN
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (instr_valid && instr_pc == 32'h3004) found = 1;
      else @(negedge clk);
    end
    chk("ds_reach_3004", 32'(found), 32'd1);
    redir_valid = 1'b1; redir_target = 32'h3100; stall = 1'b0;
    @(negedge clk);
    redir_valid = 1'b0;
    chk1("ds_slot_still_valid", instr_valid, 1'b1);
    chk("ds_slot_pc", instr_pc, 32'h3004);
    @(negedge clk);
`else
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (imem.imem_req && imem.imem_addr == 32'h3008) found = 1;
      else @(negedge clk);
    end
    chk("sq_reach_3008", 32'(found), 32'd1);
    @(negedge clk);
    chk1("sq_in_wait", imem.imem_req | instr_valid, 1'b0);
    redir_valid = 1'b1; redir_target = 32'h3100;
    @(negedge clk);
    redir_valid = 1'b0;
`endif
    got = 0; first_pc = '0; first_ins = '0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      if (instr_valid) begin
        got = 1; first_pc = instr_pc; first_ins = instr;
      end else @(negedge clk);
    end
    chk("redir_delivered", 32'(got), 32'd1);
    chk("redir_next_pc", first_pc, 32'h3100);
    chk("redir_next_instr", first_ins, mem_word(32'h3100));

    // ---------------- misaligned redirect: sticky fault and halt
    lat_min = 1; lat_max = 1;
    apply_reset();
    repeat (4) @(negedge clk);
    redir_valid = 1'b1; redir_target = 32'h3102;
    @(negedge clk);
    redir_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1("halt_fault", fault, 1'b1);
      chk1("halt_req", imem.imem_req, 1'b0);
      chk1("halt_valid", instr_valid, 1'b0);
      if (i == 3) begin redir_valid = 1'b1; redir_target = 32'h3200; end
      else redir_valid = 1'b0;
      @(negedge clk);
    end
    redir_valid = 1'b0;

    // ---------------- reset while waiting on a slow IM response
    lat_min = 4; lat_max = 4;
    apply_reset();
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (imem.imem_req && imem.imem_addr == 32'h3004) found = 1;
      else @(negedge clk);
    end
    chk("rw_reach_3004", 32'(found), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk1("rw_valid", instr_valid, 1'b0);
    chk1("rw_req", imem.imem_req, 1'b0);
    chk("rw_pc", pc, 32'h3000);
    chk("rw_instr", instr, 32'h0);
    chk("rw_instr_pc", instr_pc, 32'h0);
    chk1("rw_fault", fault, 1'b0);
    got = 0; first_pc = '0; first_ins = '0;
    for (int i = 0; i < 60 && got == 0; i++) begin
      if (instr_valid) begin
        got = 1; first_pc = instr_pc; first_ins = instr;
      end else @(negedge clk);
    end
    chk("rw_delivered", 32'(got), 32'd1);
    chk("rw_first_pc", first_pc, 32'h3000);
    chk("rw_first_instr", first_ins, mem_word(32'h3000));

    // ---------------- random traffic against the instruction-stream model
    ready_pct = 60; lat_min = 1; lat_max = 3;
    apply_reset();
    exp_next = 32'h3000; ppend = 0; ptgt = '0; consumes = 0;
    prev_req = 0; prev_ready = 0; prev_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (instr_valid) begin
        chk("rnd_instr_pc", instr_pc, exp_next);
        chk("rnd_instr", instr, mem_word(instr_pc));
      end
      chk1("rnd_req_excl", imem.imem_req & instr_valid, 1'b0);
      if (prev_req && !prev_ready) begin
        chk1("rnd_req_held", imem.imem_req, 1'b1);
        chk("rnd_addr_stable", imem.imem_addr, prev_addr);
      end
      prev_req = imem.imem_req; prev_ready = imem.imem_ready; prev_addr = imem.imem_addr;

      s = ($urandom_range(99, 0) < 30);
      r = ($urandom_range(99, 0) < 6);
      stall = s;
      redir_valid = r;
      redir_target = 32'h0000_3000 + 32'($urandom_range(1023, 0)) * 32'd4;

`ifdef DELAY_SLOT_EN
      if (r) begin
        ppend = 1; ptgt = redir_target;
      end else if (instr_valid && !s) begin
        exp_next = ppend ? ptgt : instr_pc + 32'd4;
        ppend = 0;
      end
`else
      if (r) exp_next = redir_target;
      else if (instr_valid && !s) exp_next = instr_pc + 32'd4;
`endif
      if (instr_valid && !s && !r) consumes++;
      @(negedge clk);
    end
    stall = 1'b0; redir_valid = 1'b0;
    chk1("rnd_no_fault", fault, 1'b0);
    chk("rnd_progress", (consumes > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
